ual_sequencer: RTL

UAL_SEQUENCER -- requirements
Module: ual_sequencer

---
 rtl/ual_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ual_sequencer.sv
// Sequencer for a UAL: captures operands, drives the UAL mux selects and
// accumulates the fed-back result (multi-cycle for bit-serial shifts).
module ual_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [2:0]       amount,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             ack,
   input  logic [WIDTH-1:0] ual_in,
   output logic [WIDTH-1:0] opa,
   output logic [WIDTH-1:0] opb,
   output logic             i2,
   output logic             shift_rot,
   output logic             nandi,
   output logic             ori,
   output logic             xori,
   output logic             au_sub,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned OP_W  = 3;
   localparam int unsigned CNT_W = 3;

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_NAND = OP_W'(2);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_SHL  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SHR  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_RSV  = OP_W'(7);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state_q, state_n;
   logic [WIDTH-1:0]   acc_q, acc_n;
   logic [WIDTH-1:0]   opb_q, opb_n;
   logic [OP_W-1:0]    op_q, op_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic               err_q, err_n;
   logic               is_shift_in, is_shift_q;
   logic               i2_n, shift_rot_n, nandi_n, ori_n, xori_n, au_sub_n;

   assign is_shift_in = (op == OP_SHL) || (op == OP_SHR);
   assign is_shift_q  = (op_q == OP_SHL) || (op_q == OP_SHR);

   // Next-state, datapath and registered-select decode
   always_comb begin
      state_n     = state_q;
      acc_n       = acc_q;
      opb_n       = opb_q;
      op_n        = op_q;
      cnt_n       = cnt_q;
      err_n       = err_q;
      i2_n        = 1'b0;
      shift_rot_n = 1'b0;
      nandi_n     = 1'b0;
      ori_n       = 1'b0;
      xori_n      = 1'b0;
      au_sub_n    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_n   = a_in;
               opb_n   = b_in;
               op_n    = op;
               cnt_n   = amount;
               err_n   = 1'b0;
               state_n = EXEC;
               if (op == OP_RSV) begin
                  acc_n   = '0;
                  err_n   = 1'b1;
                  state_n = DONE;
               end else if (is_shift_in && (amount == CNT_W'(0))) begin
                  state_n = DONE;
               end
            end
         end
         EXEC: begin
            acc_n = ual_in;
            if (is_shift_q) begin
               cnt_n = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_n = DONE;
            end else begin
               state_n = DONE;
            end
         end
         DONE: begin
            if (ack) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Selects follow the state being entered so they are flop outputs
      if (state_n == EXEC) begin
         case (op_n)
            OP_SUB:  au_sub_n    = 1'b1;
            OP_NAND: nandi_n     = 1'b1;
            OP_OR:   ori_n       = 1'b1;
            OP_XOR:  xori_n      = 1'b1;
            OP_SHL:  shift_rot_n = 1'b1;
            OP_SHR: begin
               shift_rot_n = 1'b1;
               i2_n        = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         opb_q     <= '0;
         op_q      <= OP_ADD;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         i2        <= 1'b0;
         shift_rot <= 1'b0;
         nandi     <= 1'b0;
         ori       <= 1'b0;
         xori      <= 1'b0;
         au_sub    <= 1'b0;
      end else begin
         state_q   <= state_n;
         acc_q     <= acc_n;
         opb_q     <= opb_n;
         op_q      <= op_n;
         cnt_q     <= cnt_n;
         err_q     <= err_n;
         busy      <= (state_n != IDLE);
         done      <= (state_n == DONE);
         i2        <= i2_n;
         shift_rot <= shift_rot_n;
         nandi     <= nandi_n;
         ori       <= ori_n;
         xori      <= xori_n;
         au_sub    <= au_sub_n;
      end
   end

   assign opa    = acc_q;
   assign opb    = opb_q;
   assign result = acc_q;
   assign err    = err_q;

endmodule
